// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core-side fetch and load/store ports of the unified memory arbiter
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, data priority with bounded fetch starvation
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  core,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [1:0] TAG_NONE   = 2'd0;
    localparam logic [1:0] TAG_I      = 2'd1;
    localparam logic [1:0] TAG_D      = 2'd2;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic       grant_i;
    logic       grant_d;
    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic [1:0] tag_d;
    logic [1:0] tag_q [MEM_LAT];

    // Fetch wins only when alone or when data has used up its streak allowance.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            if (core.i_req && (!core.d_req || streak_q >= STREAK_MAX)) begin
                grant_i = 1'b1;
            end else if (core.d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    assign core.i_gnt = grant_i;
    assign core.d_gnt = grant_d;
    assign mem_en     = grant_i | grant_d;
    assign mem_we     = grant_d & core.d_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_i) begin
            mem_addr = core.i_addr;
        end else if (grant_d) begin
            mem_addr  = core.d_addr;
            mem_wdata = core.d_wdata;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!core.i_req || grant_i) begin
            streak_d = '0;
        end else if (grant_d && streak_q < STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (grant_i) begin
            tag_d = TAG_I;
        end else if (grant_d && !core.d_we) begin
            tag_d = TAG_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
            for (int k = 0; k < MEM_LAT; k++) begin
                tag_q[k] <= TAG_NONE;
            end
        end else begin
            streak_q <= streak_d;
            tag_q[0] <= tag_d;
            for (int k = 1; k < MEM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // A response landing while reset is held belongs to a discarded read.
    assign core.i_rvalid = !reset && (tag_q[MEM_LAT-1] == TAG_I);
    assign core.d_rvalid = !reset && (tag_q[MEM_LAT-1] == TAG_D);
    assign core.i_rdata  = mem_rdata;
    assign core.d_rdata  = mem_rdata;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory between the instruction-fetch port and the load/store port of the RISC-V core, so one unified RAM backs both `Instr` and `ReadData`. Each cycle it grants at most one requester, drives the memory, and routes read data back to the owner after the memory latency. Data accesses have priority. A streak counter guarantees fetch forward progress.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MEM_LAT`, 1: memory read latency in cycles; legal range 1..4.
- `MAX_STREAK`, 3: consecutive data grants allowed while fetch waits; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_req`  in  1  fetch read request.
- `i_addr`  in  AW  fetch address.
- `i_gnt`  out  1  fetch accepted this cycle.
- `i_rvalid`  out  1  fetch data valid.
- `i_rdata`  out  DW  fetch data.
- `d_req`  in  1  load/store request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  DW  load data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after a read strobe.

## Operation
- **Request rule:** a requester holds `req`, address and write data stable until it sees `gnt`. It may keep `req` high to issue back-to-back accesses.
- **Arbitration (combinational, per cycle):**
  - Only `i_req`: grant fetch.
  - Only `d_req`: grant data.
  - Both, with `streak < MAX_STREAK`: grant data.
  - Both, with `streak == MAX_STREAK`: grant fetch.
  - Neither: no grant.
- **Grant outputs:**
  - `i_gnt` and `d_gnt` are never high together.
  - `mem_en = i_gnt | d_gnt`.
  - `mem_we = d_gnt & d_we`.
  - `mem_addr` and `mem_wdata` are muxed from the granted port.
  - `mem_addr` and `mem_wdata` are 0 when nothing is granted.
- **Streak counter (4 bits):**
  - Increments when `d_gnt & i_req`.
  - Clears on `i_gnt`, or in any cycle with `i_req = 0`.
  - Never exceeds `MAX_STREAK`.
- **Owner tag pipeline:**
  - `MEM_LAT` stages of a 2-bit tag: NONE, I, D.
  - The stage-0 input is I on `i_gnt`, D on `d_gnt & ~d_we`, NONE otherwise. Stores insert NONE.
  - `i_rvalid = (tail == I)` and `d_rvalid = (tail == D)`.
  - `i_rdata` and `d_rdata` both pass through `mem_rdata`. Their contents are meaningful only while the matching `rvalid` is high.
- **Stores:** complete at the grant cycle and never produce `d_rvalid`.
- **Ordering:** responses return in grant order, one per cycle at most. There is no internal buffering, so neither requester can be backpressured on responses.

## Timing
- **Reset:**
  - `reset` high at a rising edge clears the streak counter and all tag stages.
  - In the following cycle all registered outputs are 0: `i_rvalid` and `d_rvalid`.
  - Grant and memory outputs stay combinational. While `reset` is high they are forced to 0: `i_gnt`, `d_gnt`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`.
- **Reset mid-operation:** in-flight reads are discarded. No `rvalid` appears for any read granted before or during reset.
- **Latency:** grant in cycle T gives `mem_en` in cycle T and `rvalid` in cycle T+`MEM_LAT`.
- **Throughput:** one access per cycle total. Fully pipelined, so a new grant is possible every cycle regardless of outstanding reads.
- **Simultaneous events:**
  - A grant and a response for the same port may coincide: `rvalid` for an older read while `gnt` accepts a new one.
  - A streak saturated at `MAX_STREAK` with fetch granted clears to 0 in the next cycle.

## Test plan
- **Fetch only:** `MEM_LAT=1`, memory preloaded `0x100 -> 0x00500093`, `i_req=1`, `i_addr=0x100` for one cycle.
  - Required: `i_gnt=1` and `mem_en=1` in the same cycle.
  - Required: `i_rvalid=1` with `i_rdata=0x00500093` exactly one cycle later, and `d_rvalid` stays 0.
- **Contention and starvation:** both requesting continuously, `MAX_STREAK=3`.
  - Required grant sequence: D, D, D, I, D, D, D, I …
  - Required: `i_gnt` and `d_gnt` are never high together.
- **Store then load:** store `d_addr=0x200`, `d_wdata=0xDEADBEEF`, then load from `0x200`.
  - Required on the store grant: `mem_we=1`, `mem_wdata=0xDEADBEEF`, and no `d_rvalid` for the store.
  - Required on the load: `d_rdata=0xDEADBEEF` `MEM_LAT` cycles after its grant.
- **Latency sweep:** `MEM_LAT=3`, alternating I/D reads granted every cycle.
  - Required: responses arrive in grant order.
  - Required: each `rvalid` appears exactly 3 cycles after its grant, tagged to the correct port.
- **Reset mid-flight:** `MEM_LAT=2`, fetch granted at T, `reset` high during cycle T+1.
  - Required: no `i_rvalid` at T+2.
  - Required: streak reads 0 after reset, and all outputs are 0 while `reset` is high.
- **Streak clear:** both requesting for 2 cycles, so D and D are granted; then `i_req` drops for 1 cycle; then both request again.
  - Required: three more D grants before the next I grant, showing the counter cleared.
